prf_free_list: RTL and testbench
================================

// Module: prf_free_list
// PURPOSE
//  Allocation controller for the physical register file that feeds the rename table.
//  Circular FIFO of free PRF IDs:
//   - rename stage pops one ID per cycle for a destination write (drives RAT Allocated_PRF_ID);
//   - commit stage pushes the retired old-RD mapping back;
//   - branch-mispredict recovery rewinds the allocation pointer to a checkpoint.
//  Sits between decode/rename, the RAT and the ROB commit port.
// PARAMETERS
//  NUM_PRF   256  total physical registers; IDs are 8 bits
//  NUM_ARCH  32   architectural registers; P0..P31 are mapped at reset
//  DEPTH     NUM_PRF-NUM_ARCH (224)  free-list capacity
//  PTR_W     $clog2(DEPTH) (8)  pointer width
// PORTS
//  CLK               in   1      clock, rising edge
//  Reset             in   1      asynchronous, active-high
//  Alloc_Req         in   1      rename needs one PRF (RD != x0)
//  Alloc_Grant       out  1      Alloc_Req & ~Empty & ~Recover; pop happens this edge
//  Allocated_PRF_ID  out  8      head entry (show-ahead); valid when ~Empty
//  Free_Valid        in   1      commit returns one PRF
//  Free_PRF_ID       in   8      ID being returned (the Old_RD_PRF_ID of the retiring op)
//  Recover           in   1      mispredict: restore head to Recover_Head_Ptr
//  Recover_Head_Ptr  in   PTR_W  checkpointed head pointer
//  Head_Ptr          out  PTR_W  current head; the ROB stores it per branch as the checkpoint
//  Free_Count        out  PTR_W+1  number of free IDs, 0..DEPTH
//  Empty             out  1      Free_Count == 0; rename must stall
//  Overflow_Err      out  1      sticky: push attempted while Free_Count == DEPTH
// BEHAVIOUR
//  Reset (async, any cycle, including mid-operation):
//   - head = tail = 0; Free_Count = DEPTH; entry[i] = NUM_ARCH+i;
//   - Overflow_Err = 0; Alloc_Grant = 0; Allocated_PRF_ID = entry[0] = 32.
//  Pointer wrap: head/tail advance as (p == DEPTH-1) ? 0 : p+1 (non-power-of-2 wrap).
//  Alloc: on a cycle with Alloc_Grant = 1:
//   - head advances; Free_Count decrements;
//   - Allocated_PRF_ID is combinational from entry[head]: zero-latency grant.
//  Free: on a cycle with Free_Valid = 1, Free_PRF_ID != 0 and Free_Count < DEPTH:
//   - entry[tail] <= Free_PRF_ID; tail advances; Free_Count increments.
//   - Free_PRF_ID == 0 (x0 mapping): ignored.
//   - Free at Free_Count == DEPTH: dropped and Overflow_Err set; it clears only on Reset.
//  Simultaneous alloc + free: both occur and Free_Count is unchanged.
//   - No bypass: when Empty, a same-cycle free does not produce a grant;
//     the grant comes at earliest the next cycle.
//  Recover (highest priority over alloc):
//   - Alloc_Grant is forced to 0; head <= Recover_Head_Ptr;
//   - a same-cycle free is still applied at tail.
//   - Let t' = tail after that free.
//   - If Recover_Head_Ptr == head: Free_Count unchanged apart from the free.
//   - Otherwise: Free_Count = (t' - Recover_Head_Ptr) mod DEPTH, with a result of 0 meaning DEPTH.
//   - The entries between the checkpoint and the old head are reclaimed in place.
//  Alloc_Req while Empty: no grant and no state change; the requester holds its request.
//  Free_Count never leaves 0..DEPTH. Out-of-range IDs (>= NUM_PRF) are not checked.
// TESTING
//  1 Reset, then 3 back-to-back Alloc_Req
//     -> grants IDs 32, 33, 34; Free_Count 224 -> 221; Head_Ptr = 3.
//  2 Issue 224 allocs
//     -> last ID is 255; Empty = 1; a 225th request gets Alloc_Grant = 0.
//     Then free ID 7 -> next cycle grant returns 7.
//  3 At Free_Count = 100, alloc + free(40) in the same cycle
//     -> Free_Count stays 100; 40 is written at the old tail; tail advances.
//  4 Save Head_Ptr = 5, then alloc 4 IDs (37..40), then Recover with ptr 5
//     -> head = 5, Free_Count restored; the next grant is 37 again.
//  5 Free at Free_Count = 224 -> Overflow_Err = 1 and count unchanged;
//     free of ID 0 -> ignored.
//  6 Assert Reset asynchronously mid-burst (no clock edge)
//     -> outputs return to reset values immediately: Allocated_PRF_ID = 32, Free_Count = 224.

Source files
------------

// File: rtl/prf_free_list.sv
// -----------------------------------------------------------------------------
// prf_free_list
// Circular FIFO of free physical-register IDs feeding the rename table.
//   - Rename pops one ID per cycle (show-ahead head entry, zero-latency grant).
//   - Commit pushes the retired old-RD mapping back at the tail.
//   - Mispredict recovery rewinds the head pointer to a checkpoint; the IDs
//     between the checkpoint and the current head are reclaimed in place.
//
// Ports
//   CLK               in   1        clock, rising edge
//   Reset             in   1        asynchronous, active-high
//   Alloc_Req         in   1        rename needs one PRF
//   Alloc_Grant       out  1        pop happens on this edge
//   Allocated_PRF_ID  out  ID_W     head entry, valid when ~Empty
//   Free_Valid        in   1        commit returns one PRF
//   Free_PRF_ID       in   ID_W     ID being returned (0 is ignored)
//   Recover           in   1        restore head to Recover_Head_Ptr
//   Recover_Head_Ptr  in   PTR_W    checkpointed head pointer
//   Head_Ptr          out  PTR_W    current head (checkpoint source)
//   Free_Count        out  PTR_W+1  number of free IDs, 0..DEPTH
//   Empty             out  1        Free_Count == 0
//   Overflow_Err      out  1        sticky: push attempted while full
// -----------------------------------------------------------------------------
module prf_free_list #(
    parameter int NUM_PRF  = 256,
    parameter int NUM_ARCH = 32,
    localparam int DEPTH   = NUM_PRF - NUM_ARCH,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int ID_W    = $clog2(NUM_PRF)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Alloc_Req,
    output logic              Alloc_Grant,
    output logic [ID_W-1:0]   Allocated_PRF_ID,
    input  logic              Free_Valid,
    input  logic [ID_W-1:0]   Free_PRF_ID,
    input  logic              Recover,
    input  logic [PTR_W-1:0]  Recover_Head_Ptr,
    output logic [PTR_W-1:0]  Head_Ptr,
    output logic [PTR_W:0]    Free_Count,
    output logic              Empty,
    output logic              Overflow_Err
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    // Pointer increment with wrap at DEPTH-1 (DEPTH is not a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == LAST_C) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [ID_W-1:0]  entry_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             ovf_r;

    logic             empty_s;
    logic             grant_s;
    logic             push_s;
    logic             push_full_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [PTR_W:0]   rec_count_s;
    logic [PTR_W:0]   count_nxt_s;

    assign empty_s = (count_r == '0);

    // Grant, push qualification and the recovered occupancy.
    always_comb begin
        grant_s     = Alloc_Req & ~empty_s & ~Recover & ~Reset;
        push_s      = Free_Valid & (Free_PRF_ID != '0) & (count_r != DEPTH_C);
        push_full_s = Free_Valid & (Free_PRF_ID != '0) & (count_r == DEPTH_C);
        if (push_s) begin
            tail_nxt_s = ptr_inc(tail_r);
        end else begin
            tail_nxt_s = tail_r;
        end
        // Distance from the checkpoint to the post-push tail, modulo DEPTH;
        // a zero distance means the whole ring is free again.
        if (tail_nxt_s >= Recover_Head_Ptr) begin
            rec_count_s = {1'b0, tail_nxt_s} - {1'b0, Recover_Head_Ptr};
        end else begin
            rec_count_s = {1'b0, tail_nxt_s} + DEPTH_C - {1'b0, Recover_Head_Ptr};
        end
        if (rec_count_s == '0) begin
            rec_count_s = DEPTH_C;
        end else begin
            rec_count_s = rec_count_s;
        end
    end

    // Next occupancy: recovery overrides the pop; push and pop cancel.
    always_comb begin
        count_nxt_s = count_r;
        if (Recover) begin
            if (Recover_Head_Ptr == head_r) begin
                count_nxt_s = count_r + {{PTR_W{1'b0}}, push_s};
            end else begin
                count_nxt_s = rec_count_s;
            end
        end else begin
            case ({grant_s, push_s})
                2'b10:   count_nxt_s = count_r - (PTR_W+1)'(1);
                2'b01:   count_nxt_s = count_r + (PTR_W+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= DEPTH_C;
            ovf_r   <= 1'b0;
        end else begin
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_r | push_full_s;
            if (Recover) begin
                head_r <= Recover_Head_Ptr;
            end else if (grant_s) begin
                head_r <= ptr_inc(head_r);
            end
        end
    end

    // Free-ID storage; at reset the ring holds every unmapped ID in order.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= ID_W'(NUM_ARCH + i);
            end
        end else if (push_s) begin
            entry_r[tail_r] <= Free_PRF_ID;
        end
    end

    assign Alloc_Grant      = grant_s;
    assign Allocated_PRF_ID = entry_r[head_r];
    assign Head_Ptr         = head_r;
    assign Free_Count       = count_r;
    assign Empty            = empty_s;
    assign Overflow_Err     = ovf_r;

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// ring-buffer model built from modular arithmetic.
module tb_prf_free_list;

    localparam int DEPTH = 224;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Alloc_Req;
    logic       Alloc_Grant;
    logic [7:0] Allocated_PRF_ID;
    logic       Free_Valid;
    logic [7:0] Free_PRF_ID;
    logic       Recover;
    logic [7:0] Recover_Head_Ptr;
    logic [7:0] Head_Ptr;
    logic [8:0] Free_Count;
    logic       Empty;
    logic       Overflow_Err;

    prf_free_list dut (
        .CLK(CLK), .Reset(Reset),
        .Alloc_Req(Alloc_Req), .Alloc_Grant(Alloc_Grant),
        .Allocated_PRF_ID(Allocated_PRF_ID),
        .Free_Valid(Free_Valid), .Free_PRF_ID(Free_PRF_ID),
        .Recover(Recover), .Recover_Head_Ptr(Recover_Head_Ptr),
        .Head_Ptr(Head_Ptr), .Free_Count(Free_Count),
        .Empty(Empty), .Overflow_Err(Overflow_Err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: free IDs in a ring addressed modulo DEPTH.
    int m_mem [DEPTH];
    int m_head, m_tail, m_cnt;
    bit m_ovf;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32 + i;
        m_head = 0; m_tail = 0; m_cnt = DEPTH; m_ovf = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        return (Alloc_Req && m_cnt > 0 && !Recover && !Reset) ? 1 : 0;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("grant", Alloc_Grant, exp_grant());
            if (m_cnt > 0) chk("alloc_id", Allocated_PRF_ID, m_mem[m_head]);
            chk("head", Head_Ptr, m_head);
            chk("count", Free_Count, m_cnt);
            chk("empty", Empty, (m_cnt == 0) ? 1 : 0);
            chk("overflow", Overflow_Err, m_ovf);
        end
    end

    // Model state update on each clock edge outside reset.
    always @(posedge CLK) begin : mdl
        int g, f, d;
        if (chk_en && !Reset) begin
            g = (Alloc_Req && m_cnt > 0 && !Recover) ? 1 : 0;
            f = (Free_Valid && Free_PRF_ID != 0 && m_cnt < DEPTH) ? 1 : 0;
            if (Free_Valid && Free_PRF_ID != 0 && m_cnt == DEPTH) m_ovf = 1'b1;
            if (f == 1) begin
                m_mem[m_tail] = Free_PRF_ID;
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (Recover) begin
                if (int'(Recover_Head_Ptr) == m_head) begin
                    m_cnt = m_cnt + f;
                end else begin
                    d = (m_tail - int'(Recover_Head_Ptr) + DEPTH) % DEPTH;
                    m_cnt = (d == 0) ? DEPTH : d;
                end
                m_head = Recover_Head_Ptr;
            end else begin
                m_head = (m_head + g) % DEPTH;
                m_cnt = m_cnt + f - g;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Alloc_Req = 1'b0; Free_Valid = 1'b0; Free_PRF_ID = 8'd0;
        Recover = 1'b0; Recover_Head_Ptr = 8'd0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        cyc();
        Reset = 1'b0;
    endtask

    int last_id;

    initial begin
        idle();
        Reset = 1'b1;
        model_reset();
        chk_en = 1'b1;
        cyc(); cyc();
        Reset = 1'b0;
        chk("rst_id", Allocated_PRF_ID, 32);
        chk("rst_cnt", Free_Count, 224);
        chk("rst_ovf", Overflow_Err, 0);

        // Three back-to-back allocations.
        Alloc_Req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t1_gnt", Alloc_Grant, 1);
            chk("t1_id", Allocated_PRF_ID, 32 + k);
            cyc();
        end
        chk("t1_cnt", Free_Count, 221);
        chk("t1_head", Head_Ptr, 3);

        // Drain to empty, then no-bypass refill with ID 7.
        last_id = 0;
        for (int k = 0; k < 221; k++) begin
            @(negedge CLK);
            last_id = Allocated_PRF_ID;
            cyc();
        end
        chk("t2_last", last_id, 255);
        chk("t2_empty", Empty, 1);
        @(negedge CLK);
        chk("t2_nogrant", Alloc_Grant, 0);
        cyc();
        Free_Valid = 1'b1; Free_PRF_ID = 8'd7;
        @(negedge CLK);
        chk("t2_nobypass", Alloc_Grant, 0);
        cyc();
        Free_Valid = 1'b0;
        @(negedge CLK);
        chk("t2_regrant", Alloc_Grant, 1);
        chk("t2_id7", Allocated_PRF_ID, 7);
        cyc();
        idle();

        // Fill to 100, then simultaneous alloc + free(40).
        for (int k = 0; k < 100; k++) begin
            Free_Valid = 1'b1; Free_PRF_ID = 8'(100 + k);
            cyc();
        end
        idle();
        chk("t3_cnt100", Free_Count, 100);
        Alloc_Req = 1'b1; Free_Valid = 1'b1; Free_PRF_ID = 8'd40;
        cyc();
        idle();
        chk("t3_cnt_same", Free_Count, 100);

        // Checkpoint at head 5, allocate 37..40, recover.
        do_reset();
        Alloc_Req = 1'b1;
        repeat (5) cyc();
        chk("t4_head5", Head_Ptr, 5);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            last_id = Allocated_PRF_ID;
            cyc();
        end
        chk("t4_last40", last_id, 40);
        Recover = 1'b1; Recover_Head_Ptr = 8'd5;
        @(negedge CLK);
        chk("t4_rec_nogrant", Alloc_Grant, 0);
        cyc();
        Recover = 1'b0;
        chk("t4_head", Head_Ptr, 5);
        chk("t4_cnt", Free_Count, 219);
        chk("t4_id37", Allocated_PRF_ID, 37);
        idle();

        // Overflow when full, and ID 0 ignored.
        do_reset();
        Free_Valid = 1'b1; Free_PRF_ID = 8'd9;
        cyc();
        idle();
        chk("t5_ovf", Overflow_Err, 1);
        chk("t5_cnt", Free_Count, 224);
        Alloc_Req = 1'b1;
        cyc();
        idle();
        Free_Valid = 1'b1; Free_PRF_ID = 8'd0;
        cyc();
        idle();
        chk("t5_zero_ign", Free_Count, 223);

        // Asynchronous reset in the middle of a burst.
        Alloc_Req = 1'b1; Free_Valid = 1'b1; Free_PRF_ID = 8'd77;
        repeat (3) cyc();
        #2;
        Reset = 1'b1;
        #1;
        chk("t6_id", Allocated_PRF_ID, 32);
        chk("t6_cnt", Free_Count, 224);
        chk("t6_gnt", Alloc_Grant, 0);
        chk("t6_head", Head_Ptr, 0);
        chk("t6_ovf", Overflow_Err, 0);
        model_reset();
        idle();
        cyc();
        Reset = 1'b0;

        // Randomized traffic with alternating drain/fill bias and recoveries.
        for (int n = 0; n < 3000; n++) begin
            if (((n / 300) % 2) == 0) begin
                Alloc_Req  = ($urandom_range(0, 3) != 0);
                Free_Valid = ($urandom_range(0, 2) == 0);
            end else begin
                Alloc_Req  = ($urandom_range(0, 2) == 0);
                Free_Valid = ($urandom_range(0, 3) != 0);
            end
            Free_PRF_ID = 8'($urandom_range(0, 255));
            Recover = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0)
                Recover_Head_Ptr = 8'(m_head);
            else
                Recover_Head_Ptr = 8'($urandom_range(0, DEPTH - 1));
            cyc();
        end
        idle();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
